request_responder: RTL and testbench

Target-side counterpart of the request tracker used by the core's bus initiators. It accepts single-cycle request strobes (read or write), queues up to DEPTH of them in order, and services each against a local word-addressed memory after a fixed LATENCY. For every accepted request it returns exactly one single-cycle completion pulse, which is the signal the initiator's request tracker consumes as its request-end input. The block serves as an on-chip scratchpad and as a deterministic-latency memory model for processor benches.

---
 rtl/request_responder_pkg.sv | 32 +++
 rtl/request_responder_sync_fifo.sv | 76 +++++++
 rtl/request_responder.sv | 179 +++++++++++++++++
 tb/tb_request_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/request_responder_pkg.sv
// request_responder_pkg
// Shared types and constants for the request responder slice.
//   state_t         : servicing FSM states (IDLE, WAIT, RESP)
//   req_entry_t     : one queued request {we, addr, wdata, wstrb}
//   REQ_ENTRY_W     : packed width of req_entry_t (queue data width)
//   ERR_MISALIGNED  : value of resp_err for a misaligned request
//   isMisaligned()  : true when the byte offset within the word is non-zero
package request_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_entry_t;

  localparam int REQ_ENTRY_W = $bits(req_entry_t);

  localparam logic ERR_NONE       = 1'b0;
  localparam logic ERR_MISALIGNED = 1'b1;

  function automatic logic isMisaligned(input logic [1:0] byteOffset);
    return byteOffset != 2'b00;
  endfunction

endpackage

// File: rtl/request_responder_sync_fifo.sv
// sync_fifo
// Single-clock first-in first-out queue with registered occupancy.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (pointers/count only)
//   i_push       : write i_pushData at the tail (ignored when full)
//   i_pushData   : entry to enqueue
//   i_pop        : drop the head entry (ignored when empty)
//   o_headData   : current head entry
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
//   o_count      : number of entries held
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_pushData,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_headData,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_store [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_headData = r_store[r_rdPtr];

  // Full/empty guards make push-when-full and pop-when-empty harmless.
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_store[r_wrPtr] <= i_pushData;
    end
  end

  // DEPTH is a power of two, so the pointers simply wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/request_responder.sv
// request_responder
// Target-side request servicer: queues read/write strobes in order and
// completes each against a local word-addressed scratchpad after a fixed
// latency, returning one single-cycle completion pulse per accepted request.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : request strobe, accepted when req_valid & req_ready
//   req_ready   : queue holds fewer than DEPTH entries
//   req_we      : 1 = write, 0 = read
//   req_addr    : byte address (word index = addr[MEM_AW+1:2], upper bits wrap)
//   req_wdata   : write data
//   req_wstrb   : write byte enables
//   resp_valid  : completion pulse
//   resp_rdata  : read data on a successful read completion, else 0
//   resp_err    : misaligned-address completion
module request_responder
  import request_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int MEM_AW  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  // The counter holds the number of WAIT cycles still to run after the
  // current one, so a full wait of LATENCY-1 cycles loads LATENCY-2.
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_nextCount;

  req_entry_t        w_inEntry;
  req_entry_t        w_fifoHead;
  req_entry_t        w_head;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic [CW-1:0]     w_fifoCount;
  logic              w_accept;
  logic              w_haveWork;
  logic              w_service;
  logic              w_bypass;
  logic              w_fifoPush;
  logic              w_fifoPop;

  logic [31:0]       r_mem [2**MEM_AW];
  logic [MEM_AW-1:0] w_memIdx;
  logic              w_headErr;
  logic              w_unusedAddrBits;

  logic              r_respValid;
  logic [31:0]       r_respRdata;
  logic              r_respErr;

  assign w_inEntry = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // Ready comes only from the registered occupancy, so a full queue refuses
  // a push even in the cycle its head is popped.
  assign req_ready  = (w_fifoCount != COUNT_FULL);
  assign w_accept   = req_valid && !w_fifoFull;
  assign w_haveWork = !w_fifoEmpty || w_accept;

  // Only reachable with LATENCY=1: a request arriving at an empty queue is
  // serviced on its acceptance edge straight from the inputs.
  assign w_bypass   = w_service && w_fifoEmpty;
  assign w_fifoPush = w_accept && !w_bypass;
  assign w_fifoPop  = w_service && !w_fifoEmpty;
  assign w_head     = w_fifoEmpty ? w_inEntry : w_fifoHead;

  sync_fifo #(
    .WIDTH (REQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_fifoPush),
    .i_pushData (w_inEntry),
    .i_pop      (w_fifoPop),
    .o_headData (w_fifoHead),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // The head is serviced (popped, memory accessed, outputs loaded) on the
  // edge that enters RESP, so RESP is the cycle resp_valid is high. A push
  // seen while IDLE or RESP starts the wait immediately, which keeps the
  // acceptance-to-completion distance at exactly LATENCY.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_service   = 1'b0;
    unique case (r_state)
      IDLE, RESP: begin
        if (!w_haveWork) begin
          w_nextState = IDLE;
        end else if (LATENCY == 1) begin
          w_nextState = RESP;
          w_service   = 1'b1;
        end else begin
          w_nextState = WAIT;
          w_nextCount = CNT_LOAD;
        end
      end
      WAIT: begin
        if (r_count == '0) begin
          w_nextState = RESP;
          w_service   = 1'b1;
        end else begin
          w_nextCount = r_count - CNT_ONE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_memIdx         = w_head.addr[MEM_AW+1:2];
  assign w_headErr        = isMisaligned(w_head.addr[1:0]);
  assign w_unusedAddrBits = ^w_head.addr[31:MEM_AW+2];

  // Byte-enabled write; held off during reset so a discarded write never lands.
  always_ff @(posedge clk) begin
    if (!reset && w_service && w_head.we && !w_headErr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head.wstrb[b]) begin
          r_mem[w_memIdx][8*b +: 8] <= w_head.wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads sample memory on their own service edge, after every earlier
  // queued write has already committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_respValid <= 1'b0;
      r_respRdata <= '0;
      r_respErr   <= ERR_NONE;
    end else begin
      r_respValid <= w_service;
      r_respErr   <= (w_service && w_headErr) ? ERR_MISALIGNED : ERR_NONE;
      r_respRdata <= (w_service && !w_head.we && !w_headErr) ? r_mem[w_memIdx] : '0;
    end
  end

  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;

endmodule

// File: tb/tb_request_responder.sv
// tb_request_responder
// Directed bench for request_responder with DEPTH=4, LATENCY=3, MEM_AW=10.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, so "cycle T" is the interval following a rising edge.
module tb_request_responder;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;
  localparam int MEM_AW  = 10;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  int         acc;
  int         respIdx;
  int         pulses;
  logic       expV;
  logic [7:1] expReadyMask;

  request_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .MEM_AW  (MEM_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request from an idle block and check the whole completion
  // window: silent for LATENCY-1 cycles, pulse at LATENCY, silent after.
  task automatic issueAndCheck(input string tag, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] expData, input logic expErr);
    applyStimulus(1'b1, we, a, d, s);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k < LATENCY; k++) begin
      checkOutput({tag, " early"}, 32'(resp_valid), 32'd0);
      nextCycle();
    end
    checkOutput({tag, " valid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, " rdata"}, resp_rdata, expData);
    checkOutput({tag, " err"}, 32'(resp_err), 32'(expErr));
    nextCycle();
    checkOutput({tag, " pulse end"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, " rdata idle"}, resp_rdata, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) nextCycle();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset ready", 32'(req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset resp_err", 32'(resp_err), 32'd0);

    $display("[TB] single read latency");
    issueAndCheck("wr 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    issueAndCheck("rd 0x10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    $display("[TB] byte strobes");
    issueAndCheck("wr 0x20 all", 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
    issueAndCheck("wr 0x20 0101", 1'b1, 32'h20, 32'h12345678, 4'b0101, 32'h0, 1'b0);
    issueAndCheck("rd 0x20 merged", 1'b0, 32'h20, 32'h0, 4'h0, 32'hFF34FF78, 1'b0);
    issueAndCheck("wr 0x20 nostrb", 1'b1, 32'h20, 32'h00000000, 4'h0, 32'h0, 1'b0);
    issueAndCheck("rd 0x20 unchanged", 1'b0, 32'h20, 32'h0, 4'h0, 32'hFF34FF78, 1'b0);

    $display("[TB] misaligned and wrap");
    issueAndCheck("wr 0x100", 1'b1, 32'h100, 32'h11223344, 4'hF, 32'h0, 1'b0);
    issueAndCheck("rd 0x103 misaligned", 1'b0, 32'h103, 32'h0, 4'h0, 32'h0, 1'b1);
    issueAndCheck("wr 0x102 misaligned", 1'b1, 32'h102, 32'h0, 4'hF, 32'h0, 1'b1);
    issueAndCheck("rd 0x100 untouched", 1'b0, 32'h100, 32'h0, 4'h0, 32'h11223344, 1'b0);
    issueAndCheck("wr 0x1000 wrap", 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    issueAndCheck("rd 0x0 wrap", 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

    $display("[TB] full queue");
    for (int k = 0; k < 6; k++) begin
      issueAndCheck($sformatf("preload %0d", k), 1'b1, 32'h200 + 32'(4 * k),
                    32'hC0DE0000 + 32'(k), 4'hF, 32'h0, 1'b0);
    end
    // Requests driven in cycles 1..7. Pops land on the edges ending cycles
    // 3, 6, 9, ..., so the queue fills after cycle 5, refuses cycle 6 (full,
    // even though that edge pops) and reopens in cycle 7. Completions then
    // appear in cycles 4, 7, 10, 13, 16, 19 in issue order.
    expReadyMask = 7'b1011111;
    acc          = 0;
    respIdx      = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 7) begin
        applyStimulus(1'b1, 1'b0, 32'h200 + 32'(4 * acc), 32'h0, 4'h0);
        checkOutput($sformatf("full ready c%0d", c), 32'(req_ready), 32'(expReadyMask[c]));
        if (expReadyMask[c]) acc++;
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      expV = (c >= 4) && (c <= 19) && (((c - 4) % 3) == 0);
      checkOutput($sformatf("full resp_valid c%0d", c), 32'(resp_valid), 32'(expV));
      if (expV) begin
        checkOutput($sformatf("full rdata c%0d", c), resp_rdata, 32'hC0DE0000 + 32'(respIdx));
        respIdx++;
      end
      nextCycle();
    end
    checkOutput("full completions", 32'(respIdx), 32'd6);

    $display("[TB] reset mid-operation");
    issueAndCheck("preset 0x40", 1'b1, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0);
    issueAndCheck("preset 0x44", 1'b1, 32'h44, 32'h0, 4'hF, 32'h0, 1'b0);
    issueAndCheck("preset 0x48", 1'b1, 32'h48, 32'h0, 4'hF, 32'h0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, 1'b1, 32'h3C + 32'(4 * c), 32'hAAAA003C + 32'(4 * c), 4'hF);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rst first completion", 32'(resp_valid), 32'd1);
    nextCycle();
    reset = 1'b1;
    checkOutput("rst pulse end", 32'(resp_valid), 32'd0);
    nextCycle();
    reset = 1'b0;
    checkOutput("rst ready", 32'(req_ready), 32'd1);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (resp_valid === 1'b1) pulses++;
      nextCycle();
    end
    checkOutput("rst no completions", 32'(pulses), 32'd0);
    issueAndCheck("rd 0x40 committed", 1'b0, 32'h40, 32'h0, 4'h0, 32'hAAAA0040, 1'b0);
    issueAndCheck("rd 0x44 dropped", 1'b0, 32'h44, 32'h0, 4'h0, 32'h0, 1'b0);
    issueAndCheck("rd 0x48 dropped", 1'b0, 32'h48, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
